// File: rtl/mpadder_ctrl_if.sv
// Bundles for mpadder_ctrl: the request side facing the Montgomery FSM and
// the operand/result side facing the shared pipelined adder.
interface mpadder_ctrl_if #(
  parameter int WIDTH = 1030
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_m;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, in_a, in_b, in_m,
    input  busy, done, result
  );

  modport slave (
    input  start, op, in_a, in_b, in_m,
    output busy, done, result
  );
endinterface

interface mpadder_ctrl_add_if #(
  parameter int WIDTH = 1030
);
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_sub;
  logic [WIDTH:0]   add_result;

  modport master (
    output add_a, add_b, add_sub,
    input  add_result
  );

  modport slave (
    input  add_a, add_b, add_sub,
    output add_result
  );
endinterface

// File: rtl/mpadder_ctrl.sv
// Modular add/subtract sequencer around a shared pipelined adder: one pass for
// a borrow-free subtract, otherwise a second correction pass against m.
module mpadder_ctrl #(
  parameter int WIDTH = 1030
) (
  input logic               clk,
  input logic               reset,
  mpadder_ctrl_if.slave     req,
  mpadder_ctrl_add_if.master adder
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE1 = 3'd1,
    ST_WAIT1  = 3'd2,
    ST_ISSUE2 = 3'd3,
    ST_WAIT2  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic             r_op;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             r_add_sub;

  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_m_nxt;
  logic             w_op_nxt;
  logic [WIDTH-1:0] w_s1_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic [WIDTH-1:0] w_add_a_nxt;
  logic [WIDTH-1:0] w_add_b_nxt;
  logic             w_add_sub_nxt;

  // Low bits are the pass sum/difference; the top bit is carry (add) or borrow (sub).
  logic [WIDTH-1:0] w_pass_sum;
  logic             w_pass_flag;

  assign w_pass_sum  = adder.add_result[WIDTH-1:0];
  assign w_pass_flag = adder.add_result[WIDTH];

  assign req.busy      = r_busy;
  assign req.done      = r_done;
  assign req.result    = r_result;
  assign adder.add_a   = r_add_a;
  assign adder.add_b   = r_add_b;
  assign adder.add_sub = r_add_sub;

  // Next-state, operand routing and result selection.
  always_comb begin
    w_state_nxt   = r_state;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_m_nxt       = r_m;
    w_op_nxt      = r_op;
    w_s1_nxt      = r_s1;
    w_result_nxt  = r_result;
    w_add_a_nxt   = '0;
    w_add_b_nxt   = '0;
    w_add_sub_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req.start) begin
          w_a_nxt       = req.in_a;
          w_b_nxt       = req.in_b;
          w_m_nxt       = req.in_m;
          w_op_nxt      = req.op;
          w_add_a_nxt   = req.in_a;
          w_add_b_nxt   = req.in_b;
          w_add_sub_nxt = req.op;
          w_state_nxt   = ST_ISSUE1;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_ISSUE1: begin
        w_add_a_nxt   = r_a;
        w_add_b_nxt   = r_b;
        w_add_sub_nxt = r_op;
        w_state_nxt   = ST_WAIT1;
      end
      ST_WAIT1: begin
        w_s1_nxt = w_pass_sum;
        if (!r_op) begin
          // Trial subtraction of m; its borrow decides whether s1 is kept.
          w_add_a_nxt   = w_pass_sum;
          w_add_b_nxt   = r_m;
          w_add_sub_nxt = 1'b1;
          w_state_nxt   = ST_ISSUE2;
        end else if (w_pass_flag) begin
          // Negative difference in two's complement: wrap it back by adding m.
          w_add_a_nxt   = w_pass_sum;
          w_add_b_nxt   = r_m;
          w_add_sub_nxt = 1'b0;
          w_state_nxt   = ST_ISSUE2;
        end else begin
          w_result_nxt  = w_pass_sum;
          w_state_nxt   = ST_DONE;
        end
      end
      ST_ISSUE2: begin
        w_add_a_nxt   = r_add_a;
        w_add_b_nxt   = r_add_b;
        w_add_sub_nxt = r_add_sub;
        w_state_nxt   = ST_WAIT2;
      end
      ST_WAIT2: begin
        if (!r_op) begin
          w_result_nxt = w_pass_flag ? r_s1 : w_pass_sum;
        end else begin
          w_result_nxt = w_pass_sum;
        end
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also drops any coincident request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_m       <= '0;
      r_op      <= 1'b0;
      r_s1      <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_sub <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_m       <= w_m_nxt;
      r_op      <= w_op_nxt;
      r_s1      <= w_s1_nxt;
      r_result  <= w_result_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= (w_state_nxt == ST_DONE);
      r_add_a   <= w_add_a_nxt;
      r_add_b   <= w_add_b_nxt;
      r_add_sub <= w_add_sub_nxt;
    end
  end

endmodule

// File: tb/tb_mpadder_ctrl.sv
// Scoreboard bench for mpadder_ctrl: a one-stage adder stand-in, a plain
// arithmetic reference for (a +/- b) mod m, and a monitor popping on done.
module tb_mpadder_ctrl;
  localparam int W = 1030;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mpadder_ctrl_if     #(.WIDTH(W)) req_if ();
  mpadder_ctrl_add_if #(.WIDTH(W)) add_if ();

  mpadder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req_if),
    .adder (add_if)
  );

  // Adder stand-in: result one edge after operands, top bit carry/borrow.
  always_ff @(posedge clk) begin
    if (reset) add_if.add_result <= '0;
    else if (add_if.add_sub) add_if.add_result <= {1'b0, add_if.add_a} - {1'b0, add_if.add_b};
    else add_if.add_result <= {1'b0, add_if.add_a} + {1'b0, add_if.add_b};
  end

  typedef struct {
    logic [W-1:0] res;
    int           t0;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] last_res = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (low 160 bits)", name, act[159:0], exp[159:0]);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mod(input bit op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] m);
    logic [W+1:0] aa, bb, mm, r;
    aa = {2'b00, a};
    bb = {2'b00, b};
    mm = {2'b00, m};
    if (!op) r = (aa + bb) % mm;
    else if (aa >= bb) r = aa - bb;
    else r = aa + mm - bb;
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [1055:0] t;
    for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((req_if.busy || req_if.done) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy after %0d cycles required idle", n);
    end
  endtask

  // Issue one request from IDLE; returns at the negedge of the ISSUE1 cycle.
  task automatic issue(input bit op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] m);
    exp_t e;
    wait_idle();
    chk_w("result_hold", req_if.result, last_res);
    chk_i("idle_add_sub", int'(add_if.add_sub), 0);
    req_if.start = 1'b1;
    req_if.op    = op;
    req_if.in_a  = a;
    req_if.in_b  = b;
    req_if.in_m  = m;
    e.res = ref_mod(op, a, b, m);
    e.t0  = cyc;
    e.lat = (op && a >= b) ? 3 : 5;
    sb.push_back(e);
    @(negedge clk);
    req_if.start = 1'b0;
    req_if.op    = 1'($urandom);
    req_if.in_a  = rand_wide();
    req_if.in_b  = rand_wide();
    req_if.in_m  = rand_wide();
    chk_i("issue1_busy", int'(req_if.busy), 1);
    chk_w("issue1_add_a", add_if.add_a, a);
    chk_w("issue1_add_b", add_if.add_b, b);
    chk_i("issue1_add_sub", int'(add_if.add_sub), int'(op));
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (req_if.done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required no done");
        end else begin
          e = sb.pop_front();
          chk_w("result", req_if.result, e.res);
          chk_i("latency", cyc - e.t0, e.lat);
          chk_i("done_busy", int'(req_if.busy), 1);
          last_res = e.res;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] mf, ones, mask, m, a, b;
    int           bits;
    int           n;
    ones = '1;
    mf = ones >> 1;
    mf[W-1] = 1'b0;
    mf = {1'b0, ones[W-2:0]};

    reset        = 1'b1;
    req_if.start = 1'b0;
    req_if.op    = 1'b0;
    req_if.in_a  = '0;
    req_if.in_b  = '0;
    req_if.in_m  = '0;
    repeat (3) @(negedge clk);
    chk_i("rst_busy", int'(req_if.busy), 0);
    chk_i("rst_done", int'(req_if.done), 0);
    chk_w("rst_result", req_if.result, '0);
    chk_w("rst_add_a", add_if.add_a, '0);
    chk_w("rst_add_b", add_if.add_b, '0);
    chk_i("rst_add_sub", int'(add_if.add_sub), 0);
    reset = 1'b0;

    // 5+7 mod 11 with stray starts in cycles 2 and 4 and a second-pass peek.
    issue(1'b0, W'(5), W'(7), W'(11));
    @(negedge clk);
    req_if.start = 1'b1;
    req_if.op    = 1'b1;
    @(negedge clk);
    req_if.start = 1'b0;
    chk_i("issue2_add_sub", int'(add_if.add_sub), 1);
    chk_w("issue2_add_a", add_if.add_a, W'(12));
    chk_w("issue2_add_b", add_if.add_b, W'(11));
    @(negedge clk);
    req_if.start = 1'b1;
    @(negedge clk);
    req_if.start = 1'b0;

    issue(1'b0, W'(3), W'(4), W'(11));
    issue(1'b0, W'(6), W'(5), W'(11));
    issue(1'b1, W'(8), W'(3), W'(11));
    issue(1'b1, W'(3), W'(8), W'(11));
    issue(1'b0, mf - W'(1), mf - W'(1), mf);
    issue(1'b1, W'(0), mf - W'(1), mf);

    // Reset in cycle 3 of an add: aborts with no done and clears result.
    issue(1'b0, W'(5), W'(7), W'(11));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_i("abort_busy", int'(req_if.busy), 0);
    chk_i("abort_done", int'(req_if.done), 0);
    chk_w("abort_result", req_if.result, '0);
    sb.delete();
    last_res = '0;
    reset = 1'b0;
    issue(1'b0, W'(5), W'(7), W'(11));

    // Start coincident with reset is dropped.
    wait_idle();
    reset        = 1'b1;
    req_if.start = 1'b1;
    req_if.in_a  = W'(2);
    req_if.in_b  = W'(3);
    req_if.in_m  = W'(11);
    @(negedge clk);
    reset        = 1'b0;
    req_if.start = 1'b0;
    @(negedge clk);
    chk_i("rst_start_busy", int'(req_if.busy), 0);
    chk_w("rst_start_add_a", add_if.add_a, '0);
    last_res = '0;

    for (int k = 0; k < 40; k++) begin
      bits = $urandom_range(2, W - 1);
      mask = ones >> (W - bits);
      m = rand_wide() & mask;
      if (m < W'(2)) m = W'(2);
      a = rand_wide() % m;
      b = rand_wide() % m;
      if (k % 8 == 3) a = m - W'(1);
      if (k % 8 == 5) b = m - W'(1);
      if (k % 8 == 6) b = a;
      issue(1'($urandom), a, b, m);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpadder_ctrl.md
# mpadder_ctrl

Sequencing controller that turns the shared two-stage pipelined 1030-bit adder/subtractor (`mpadderD`) into a modular add/subtract unit. It performs one or two adder passes per request and returns `(a + b) mod m` or `(a − b) mod m`. It sits between the Montgomery top-level FSM and the adder instance and owns the adder's operand and `subtract` inputs exclusively.

## Interface
- `WIDTH`, 1030, operand width; equals the adder input width.
- `clk` input 1: single clock for block and adder.
- `reset` input 1: synchronous, active-high; same net as the adder's `reset`.
- `start` input 1: request strobe; sampled only in IDLE.
- `op` input 1: 0 = modular add, 1 = modular subtract.
- `in_a`, `in_b`, `in_m` input WIDTH each: operands; must satisfy a, b < m < 2^(WIDTH−1).
- `busy` output 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done` output 1: one-cycle pulse in DONE.
- `result` output WIDTH: modular result; held from DONE until the next completion.
- `add_a`, `add_b` output WIDTH each: registered operands to the adder.
- `add_sub` output 1: registered `subtract` to the adder.
- `add_result` input WIDTH+1: adder result.
  - Valid one cycle after operands are presented at a clock edge.
  - For subtraction, bit WIDTH = 1 means borrow (a < b).

## Operation
- States: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE.
- **IDLE**
  - `start`=1: latch `in_a`, `in_b`, `in_m`, `op` into internal registers.
  - Drive `add_a`=a, `add_b`=b, `add_sub`=op.
  - Go to ISSUE1.
  - `start`=0: `add_a`/`add_b`/`add_sub` = 0.
- **ISSUE1**: operands stable on the adder; the adder registers them at this cycle's edge. Go to WAIT1.
- **WAIT1**: capture `add_result[WIDTH-1:0]` into s1 and `add_result[WIDTH]` into flag f1, then decide:
  - op=0: always go to ISSUE2 with `add_a`=s1, `add_b`=m, `add_sub`=1.
  - op=1, f1=1 (borrow): go to ISSUE2 with `add_a`=s1 (two's complement, low WIDTH bits), `add_b`=m, `add_sub`=0.
  - op=1, f1=0: `result`←s1, go to DONE.
- **ISSUE2**: go to WAIT2.
- **WAIT2**: capture the second adder result into s2 and flag f2, then go to DONE with:
  - op=0: `result` = f2 ? s1 : s2, i.e. keep s1 when s1 < m, else s1 − m.
  - op=1: `result` = s2[WIDTH−1:0]; the carry-out of the wrap is discarded.
- **DONE**: `done`=1, `busy`=1. Go to IDLE.
  - `start` is not accepted in DONE, so back-to-back requests are spaced by one IDLE cycle.
- **Width rules**
  - The precondition m < 2^(WIDTH−1) guarantees a + b < 2^WIDTH, so s1 fits in WIDTH bits.
  - No result bit is ever truncated for legal inputs.
  - Illegal inputs give an undefined `result` but the state sequence is unchanged.
- **Busy behaviour**: `start` while busy is ignored; operand registers are not disturbed. `in_*` may change freely after acceptance.
- **Operand hold**: `add_a`/`add_b`/`add_sub` are held through each ISSUE→WAIT pair and return to 0 in IDLE.

## Timing
- Cycle 0: IDLE with `start`=1. ISSUE1 in cycle 1, WAIT1 in cycle 2.
- Latency from `start` to `done`:
  - Two-pass operations (all adds, and subtracts with borrow): DONE in cycle 5.
  - Single-pass operation (subtract without borrow): DONE in cycle 3.
- `result` changes only on the edge entering DONE and is stable while `done`=1.
- Reset values: state IDLE; `busy`=0, `done`=0, `result`=0, `add_a`=0, `add_b`=0, `add_sub`=0; internal s1/s2/f1/f2/operand registers 0.
- Reset asserted mid-operation:
  - Abort on the next edge to IDLE; no `done` pulse.
  - `result` is cleared to 0.
  - The adder pipeline is cleared by the same reset.
- `start` coincident with `reset`: reset wins; the request is dropped.

## Test plan
- op=0, a=5, b=7, m=11: `done` in cycle 5, `result`=1; `add_sub` sequence 0 then 1.
- op=0, a=3, b=4, m=11: `result`=7, second pass borrows so s1 is kept; a=6, b=5, m=11 (sum equals m): `result`=0.
- op=1, a=8, b=3, m=11: `done` in cycle 3, `result`=5, single pass. op=1, a=3, b=8, m=11: `done` in cycle 5, `result`=6.
- Full width, m=2^1029−1, op=0, a=b=m−1: `result`=m−2. Then op=1, a=0, b=m−1: `result`=1.
- `start` pulsed in cycles 2 and 4 of an add: ignored, single `done`, `result` matches the first request. A new `start` in the cycle after DONE is accepted.
- `reset` asserted in cycle 3 of an add: `busy`=0, `result`=0 the next cycle, no `done`. A following request (5+7 mod 11) completes correctly with `result`=1.
